bcd_countdown: RTL and testbench

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

---
 rtl/bcd_countdown_pkg.sv | 31 +++
 rtl/seven_seg_decoder.sv | 27 ++
 rtl/bcd_countdown.sv | 113 +++++++++++
 tb/tb_bcd_countdown.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_pkg.sv
// Shared types and constants for the BCD countdown timer and its display decoders.
// Segment patterns are active-low, bit 0 = segment a, bit 6 = segment g.
package bcd_countdown_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal nibbles saturate to 9 so the counter never holds A-F.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Codes A-F display blank; the counter never produces them.
module seven_seg_decoder
  import bcd_countdown_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_countdown.sv
// Four-digit BCD down counter with load, pause, optional auto-reload and
// a one-cycle done pulse; drives four 7-segment displays.
module bcd_countdown
  import bcd_countdown_pkg::*;
#(
  parameter int AUTO_RELOAD = 0
)
(
  input  logic        clock,
  input  logic        clear_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] loadval,
  input  logic        tick,
  output logic [15:0] count,
  output logic        zero,
  output logic        done,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  state_t      state_reg;
  logic [15:0] count_reg;
  logic [15:0] reload_reg;
  logic        done_reg;

  logic [15:0]           count_dec;
  logic [15:0]           load_clamped;
  logic [NUM_DIGITS-1:0] borrow;
  logic [6:0]            hex_seg [NUM_DIGITS];

  // The least significant digit always receives the decrement.
  assign borrow[0] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [BCD_W-1:0] dig;

    assign dig = count_reg[gi*BCD_W +: BCD_W];
    assign count_dec[gi*BCD_W +: BCD_W] =
      !borrow[gi]     ? dig :
      (dig == 4'd0)   ? 4'd9 :
                        dig - 4'd1;
    assign load_clamped[gi*BCD_W +: BCD_W] = clamp_digit(loadval[gi*BCD_W +: BCD_W]);

    if (gi < NUM_DIGITS - 1) begin : g_borrow
      assign borrow[gi+1] = borrow[gi] & (dig == 4'd0);
    end

    seven_seg_decoder u_seg (
      .digit (dig),
      .seg   (hex_seg[gi])
    );
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_reg  <= IDLE;
      count_reg  <= 16'h0000;
      reload_reg <= 16'h0000;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        count_reg  <= load_clamped;
        reload_reg <= load_clamped;
        state_reg  <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (enable && (count_reg != 16'h0000)) begin
              state_reg <= RUN;
            end
          end
          RUN: begin
            if (!enable) begin
              state_reg <= IDLE;
            end else if (tick) begin
              // Reaching zero expires the count instead of storing 0000 in reload mode.
              if (count_reg == 16'h0001) begin
                done_reg <= 1'b1;
                if (AUTO_RELOAD != 0) begin
                  count_reg <= reload_reg;
                end else begin
                  count_reg <= 16'h0000;
                  state_reg <= DONE;
                end
              end else begin
                count_reg <= count_dec;
              end
            end
          end
          DONE: begin
            if (!enable) begin
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign count = count_reg;
  assign done  = done_reg;
  assign zero  = (count_reg == 16'h0000);
  assign hex0  = hex_seg[0];
  assign hex1  = hex_seg[1];
  assign hex2  = hex_seg[2];
  assign hex3  = hex_seg[3];

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: one instance per AUTO_RELOAD setting, shared stimulus,
// a decimal-arithmetic reference model, a vector table and directed sequences.
module tb_bcd_countdown;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] loadval = 16'h0000;
  logic        tick = 1'b0;

  logic [15:0] cnt [2];
  logic        zr [2];
  logic        dn [2];
  logic [6:0]  hx0 [2];
  logic [6:0]  hx1 [2];
  logic [6:0]  hx2 [2];
  logic [6:0]  hx3 [2];

  int n_checks = 0;
  int n_fail   = 0;

  int m_st [2];
  int m_val [2];
  int m_rel [2];
  int m_done [2];

  logic [6:0] seg_tab [10];

  typedef struct {
    logic        clear_n;
    logic        enable;
    logic        load;
    logic [15:0] loadval;
    logic        tick;
    logic [15:0] exp_count;
    logic        exp_zero;
    logic        exp_done;
  } vec_t;

  vec_t vecs [20];

  always #5 clock = ~clock;

  bcd_countdown #(.AUTO_RELOAD(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .enable(enable), .load(load),
    .loadval(loadval), .tick(tick), .count(cnt[0]), .zero(zr[0]), .done(dn[0]),
    .hex0(hx0[0]), .hex1(hx1[0]), .hex2(hx2[0]), .hex3(hx3[0])
  );

  bcd_countdown #(.AUTO_RELOAD(1)) dut1 (
    .clock(clock), .clear_n(clear_n), .enable(enable), .load(load),
    .loadval(loadval), .tick(tick), .count(cnt[1]), .zero(zr[1]), .done(dn[1]),
    .hex0(hx0[1]), .hex1(hx1[1]), .hex2(hx2[1]), .hex3(hx3[1])
  );

  function automatic int bcd_to_int(input logic [15:0] b);
    int v = 0;
    int w = 1;
    for (int k = 0; k < 4; k++) begin
      int d = int'(b[4*k +: 4]);
      if (d > 9) d = 9;
      v = v + d * w;
      w = w * 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour: counts in plain decimal, one call per rising edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!clear_n) begin
        m_st[i] = M_IDLE; m_val[i] = 0; m_rel[i] = 0; m_done[i] = 0;
      end else begin
        m_done[i] = 0;
        if (load) begin
          m_val[i] = bcd_to_int(loadval);
          m_rel[i] = m_val[i];
          m_st[i]  = M_IDLE;
        end else if (m_st[i] == M_IDLE) begin
          if (enable && m_val[i] != 0) m_st[i] = M_RUN;
        end else if (m_st[i] == M_RUN) begin
          if (!enable) begin
            m_st[i] = M_IDLE;
          end else if (tick) begin
            m_val[i] = m_val[i] - 1;
            if (m_val[i] == 0) begin
              m_done[i] = 1;
              if (i == 1) m_val[i] = m_rel[i];
              else m_st[i] = M_DONE;
            end
          end
        end else if (!enable) begin
          m_st[i] = M_IDLE;
        end
      end
    end
  endtask

  task automatic check_model(input int i);
    int v = m_val[i];
    chk($sformatf("dut%0d count", i), 32'(cnt[i]), 32'(int_to_bcd(v)));
    chk($sformatf("dut%0d zero", i), 32'(zr[i]), 32'(v == 0));
    chk($sformatf("dut%0d done", i), 32'(dn[i]), 32'(m_done[i]));
    chk($sformatf("dut%0d hex0", i), 32'(hx0[i]), 32'(seg_tab[v % 10]));
    chk($sformatf("dut%0d hex1", i), 32'(hx1[i]), 32'(seg_tab[v / 10 % 10]));
    chk($sformatf("dut%0d hex2", i), 32'(hx2[i]), 32'(seg_tab[v / 100 % 10]));
    chk($sformatf("dut%0d hex3", i), 32'(hx3[i]), 32'(seg_tab[v / 1000 % 10]));
  endtask

  task automatic step(input logic c, input logic e, input logic l,
                      input logic [15:0] lv, input logic t);
    clear_n = c; enable = e; load = l; loadval = lv; tick = t;
    @(posedge clock);
    model_edge();
    #1;
    check_model(0);
    check_model(1);
    $display("step clr_n=%b en=%b ld=%b lv=%h tk=%b | ar0 count=%h done=%b | ar1 count=%h done=%b",
             c, e, l, lv, t, cnt[0], dn[0], cnt[1], dn[1]);
  endtask

  initial begin
    int pulses;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_val[i] = 0; m_rel[i] = 0; m_done[i] = 0;
    end

    // clear_n, enable, load, loadval, tick -> count, zero, done (AUTO_RELOAD=0)
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0A3F, 1'b0, 16'h0939, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h1230, 1'b1, 16'h1230, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1230, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1229, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h1229, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h1000, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0999, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0009, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 1'b0};

    for (int v = 0; v < 20; v++) begin
      step(vecs[v].clear_n, vecs[v].enable, vecs[v].load, vecs[v].loadval, vecs[v].tick);
      chk($sformatf("vec%0d count", v), 32'(cnt[0]), 32'(vecs[v].exp_count));
      chk($sformatf("vec%0d zero", v), 32'(zr[0]), 32'(vecs[v].exp_zero));
      chk($sformatf("vec%0d done", v), 32'(dn[0]), 32'(vecs[v].exp_done));
    end

    // Reset state
    step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1);
    chk("reset count", 32'(cnt[0]), 32'h0000);
    chk("reset zero", 32'(zr[0]), 32'h1);
    chk("reset hex3", 32'(hx3[0]), 32'h40);

    // 0100 down through the digit borrows to expiry
    step(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    chk("borrow 0100->0099", 32'(cnt[0]), 32'h0099);
    pulses = 0;
    for (int k = 0; k < 99; k++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      if (dn[0]) pulses++;
    end
    chk("expiry count", 32'(cnt[0]), 32'h0000);
    chk("expiry done", 32'(dn[0]), 32'h1);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    if (dn[0]) pulses++;
    chk("done pulse width", 32'(pulses), 32'd1);
    chk("done state holds 0000", 32'(cnt[0]), 32'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Load beats a simultaneous tick
    step(1'b1, 1'b0, 1'b1, 16'h0003, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h0050, 1'b1);
    chk("load over tick", 32'(cnt[0]), 32'h0050);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    chk("idle after load", 32'(cnt[0]), 32'h0050);

    // Auto-reload sequence
    step(1'b1, 1'b0, 1'b1, 16'h0002, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      chk($sformatf("reload seq %0d", k), 32'(cnt[1]), (k % 2 == 0) ? 32'h0001 : 32'h0002);
      if (k < 3 && dn[1]) pulses++;
      if (k == 1) chk("reload first done", 32'(dn[1]), 32'h1);
    end
    chk("reload done pulses", 32'(pulses), 32'd1);

    // Pause, then a synchronous clear in the middle of a run
    step(1'b1, 1'b0, 1'b1, 16'h0500, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    chk("run to 0497", 32'(cnt[0]), 32'h0497);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("paused 0497", 32'(cnt[0]), 32'h0497);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    clear_n = 1'b0; enable = 1'b1; tick = 1'b1;
    #3;
    chk("clear not async", 32'(cnt[0]), 32'h0497);
    @(posedge clock);
    model_edge();
    #1;
    check_model(0);
    check_model(1);
    chk("clear mid-run count", 32'(cnt[0]), 32'h0000);
    chk("clear mid-run done", 32'(dn[0]), 32'h0);
    $display("step clr_n=0 en=1 tk=1 mid-run | ar0 count=%h done=%b", cnt[0], dn[0]);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      logic c, e, l, t;
      logic [15:0] lv;
      c  = ($urandom_range(199) != 0);
      l  = ($urandom_range(11) == 0);
      lv = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(37));
      e  = ($urandom_range(7) != 0);
      t  = ($urandom_range(2) != 0);
      step(c, e, l, lv, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
